// File: rtl/serial_store_collector_pkg.sv
// Shared definitions for the serial store collector.
//   - RISC-V store funct3 codes (SB/SH/SW)
//   - collector state enum (IDLE/COLLECT/HOLD)
//   - word/mask width constants
//   - helpers: store legality, lane mask and last-bit index per store width
package serial_store_collector_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 5;

  localparam logic [2:0] F_SB = 3'b000;
  localparam logic [2:0] F_SH = 3'b001;
  localparam logic [2:0] F_SW = 3'b010;

  localparam logic [MASK_W-1:0] MASK_B = 4'b0001;
  localparam logic [MASK_W-1:0] MASK_H = 4'b0011;
  localparam logic [MASK_W-1:0] MASK_F = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // A store is accepted only when its width is known and its offset is
  // naturally aligned for that width.
  function automatic logic store_legal(input logic [2:0] func, input logic [1:0] off);
    logic ok;
    case (func)
      F_SB:    ok = 1'b1;
      F_SH:    ok = ~off[0];
      F_SW:    ok = (off == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [MASK_W-1:0] store_mask(input logic [2:0] func, input logic [1:0] off);
    logic [MASK_W-1:0] m;
    case (func)
      F_SB:    m = MASK_B << off;
      F_SH:    m = MASK_H << off;
      default: m = MASK_F;
    endcase
    return m;
  endfunction

  // Index of the final stream bit (N-1).
  function automatic logic [CNT_W-1:0] store_last(input logic [2:0] func);
    logic [CNT_W-1:0] l;
    case (func)
      F_SB:    l = 5'd7;
      F_SH:    l = 5'd15;
      default: l = 5'd31;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/serial_store_collector_if.sv
// Memory-side port of the serial store collector: one assembled store per
// transfer, handed over with a valid/ready handshake.
//   word_out  : assembled word, lanes outside mask_out are zero
//   mask_out  : byte write enables
//   addr_out  : word address of the entry
//   out_valid : an entry is presented
//   out_ready : memory accepts the presented entry
// master = collector side, slave = memory side.
interface serial_store_collector_if #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [D_WIDTH-1:0]    word_out;
  logic [3:0]            mask_out;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output word_out, mask_out, addr_out, out_valid,
    input  out_ready
  );

  modport slave (
    input  word_out, mask_out, addr_out, out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_store_collector_store_fifo2.sv
// store_fifo2: two-entry FIFO holding packed {addr, mask, word} entries.
//   clk, rst : clock, synchronous active-high reset (pointers only)
//   i_push   : write i_din into the tail
//   i_pop    : drop the head (caller only pops when not empty)
//   i_din    : entry to write
//   o_dout   : head entry, read straight from storage registers
//   o_full   : both slots occupied
//   o_empty  : no slot occupied
// Push and pop in the same cycle are allowed even when full: the popped
// slot is the one the push overwrites.
module store_fifo2 #(
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop)  r_rd <= ~r_rd;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is data only; validity comes from the counter.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
endmodule

// File: rtl/serial_store_collector.sv
// serial_store_collector: receives LSB-first serial store data and assembles
// a byte-lane-aligned word with write mask and word address, queued in a
// two-entry buffer toward the memory port.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a store, latching func/byte_offset/word_addr
//   func        : funct3 store width (SB/SH/SW)
//   byte_offset : address bits [1:0]
//   word_addr   : word address of the store
//   bit_in      : serial data bit, qualified by bit_valid
//   m_if        : memory-side handshake port (word/mask/addr/valid/ready)
//   busy        : collecting or holding a completed word
//   misaligned  : one-cycle pulse for a rejected (misaligned/illegal) start
//   overrun     : sticky protocol error, cleared only by rst
module serial_store_collector
  import serial_store_collector_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            func,
  input  logic [1:0]            byte_offset,
  input  logic [ADDR_WIDTH-1:0] word_addr,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  serial_store_collector_if.master m_if,
  output logic                  busy,
  output logic                  misaligned,
  output logic                  overrun
);
  localparam int ENT_W = ADDR_WIDTH + MASK_W + D_WIDTH;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_last;
  logic [1:0]            r_off;
  logic [MASK_W-1:0]     r_mask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0]    r_word;
  logic                  r_misaligned;
  logic                  r_overrun;

  logic                  w_idle;
  logic                  w_collect;
  logic                  w_hold;
  logic                  w_legal;
  logic                  w_begin;
  logic                  w_take;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_off;
  logic [CNT_W-1:0]      w_cnt;
  logic [CNT_W-1:0]      w_pos;
  logic [D_WIDTH-1:0]    w_base;
  logic [D_WIDTH-1:0]    w_word_upd;
  logic [D_WIDTH-1:0]    w_push_word;
  logic [ENT_W-1:0]      w_din;
  logic [ENT_W-1:0]      w_head;

  assign w_idle    = (r_state == S_IDLE);
  assign w_collect = (r_state == S_COLLECT);
  assign w_hold    = (r_state == S_HOLD);
  assign w_legal   = store_legal(func, byte_offset);
  assign w_begin   = start & w_idle & w_legal;
  assign w_pop     = ~w_empty & m_if.out_ready;

  // The start cycle may already carry bit 0, so placement uses the
  // incoming offset and a zero count/word until those are latched.
  assign w_take     = bit_valid & (w_begin | w_collect);
  assign w_off      = w_begin ? byte_offset : r_off;
  assign w_cnt      = w_begin ? '0 : r_cnt;
  assign w_base     = w_begin ? '0 : r_word;
  assign w_pos      = {w_off, 3'b000} + w_cnt;
  assign w_word_upd = w_take ? (w_base | (D_WIDTH'(bit_in) << w_pos)) : w_base;

  // A full buffer still accepts the finished word if the head leaves in
  // the same cycle; otherwise the word parks in HOLD.
  assign w_last      = w_collect & bit_valid & (r_cnt == r_last);
  assign w_push      = (w_last & (~w_full | w_pop)) | (w_hold & w_pop);
  assign w_push_word = w_hold ? r_word : w_word_upd;
  assign w_din       = {r_addr, r_mask, w_push_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_misaligned <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_misaligned <= start & w_idle & ~w_legal;
      if ((start & ~w_idle) | (bit_valid & w_idle & ~start) | (bit_valid & w_hold))
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_begin) begin
            r_state <= S_COLLECT;
            r_cnt   <= bit_valid ? CNT_W'(1) : '0;
          end
        end
        S_COLLECT: begin
          if (bit_valid) begin
            if (r_cnt == r_last) begin
              r_cnt   <= '0;
              r_state <= (w_full & ~w_pop) ? S_HOLD : S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (w_pop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store descriptor and assembly word are data only and need no reset:
  // a new store always starts from a cleared word.
  always_ff @(posedge clk) begin
    if (w_begin) begin
      r_off  <= byte_offset;
      r_mask <= store_mask(func, byte_offset);
      r_addr <= word_addr;
      r_last <= store_last(func);
    end
    r_word <= w_word_upd;
  end

  store_fifo2 #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields are forced to zero while nothing is queued.
  assign m_if.out_valid = ~w_empty;
  assign m_if.word_out  = w_empty ? '0 : w_head[D_WIDTH-1:0];
  assign m_if.mask_out  = w_empty ? '0 : w_head[D_WIDTH +: MASK_W];
  assign m_if.addr_out  = w_empty ? '0 : w_head[D_WIDTH+MASK_W +: ADDR_WIDTH];

  assign busy       = ~w_idle;
  assign misaligned = r_misaligned;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_serial_store_collector.sv
module tb_serial_store_collector;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] func;
  logic [1:0] boff;
  logic [9:0] waddr;
  logic       bit_in;
  logic       bit_valid;
  logic       busy;
  logic       mis;
  logic       ovr;

  serial_store_collector_if #(.D_WIDTH(32), .ADDR_WIDTH(10)) ifc ();

  serial_store_collector #(.D_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .func        (func),
    .byte_offset (boff),
    .word_addr   (waddr),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .m_if        (ifc),
    .busy        (busy),
    .misaligned  (mis),
    .overrun     (ovr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [31:0] word;
  } ent_t;

  // Reference model state (post-edge view)
  ent_t        m_q[$];
  ent_t        m_held;
  bit          m_active;
  bit          m_hold;
  bit          m_mis;
  bit          m_ovr;
  int          m_n;
  int          m_k;
  logic [1:0]  m_off;
  logic [2:0]  m_func;
  logic [9:0]  m_addr;
  logic [31:0] m_val;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] f, input logic [1:0] off);
    return (f <= 3'd2) && ((int'(off) % (1 << int'(f))) == 0);
  endfunction

  // Advance the model across one rising edge using the inputs the DUT saw.
  task automatic model_edge();
    bit   pop;
    bit   idle;
    bit   push;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_active = 0; m_hold = 0; m_mis = 0; m_ovr = 0;
      return;
    end
    pop  = (m_q.size() > 0) && ifc.out_ready;
    idle = !m_active && !m_hold;
    push = 0;
    e    = '0;
    m_mis = 0;
    if ((start && !idle) || (bit_valid && idle && !start) || (bit_valid && m_hold))
      m_ovr = 1;
    if (idle && start) begin
      if (m_legal(func, boff)) begin
        m_active = 1; m_func = func; m_n = 8 << int'(func);
        m_off = boff; m_addr = waddr; m_val = '0; m_k = 0;
        if (bit_valid) begin m_val[0] = bit_in; m_k = 1; end
      end else begin
        m_mis = 1;
      end
    end else if (m_active && bit_valid) begin
      m_val[m_k] = bit_in;
      m_k++;
      if (m_k == m_n) begin
        m_active = 0;
        e.addr = m_addr;
        e.mask = 4'(((1 << (m_n / 8)) - 1) << int'(m_off));
        e.word = m_val << (8 * int'(m_off));
        if (m_q.size() < 2 || pop) push = 1;
        else begin m_hold = 1; m_held = e; end
      end
    end else if (m_hold && pop) begin
      e = m_held; push = 1; m_hold = 0;
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", ifc.out_valid, m_q.size() > 0);
      chk("busy", busy, m_active || m_hold);
      chk("misaligned", mis, m_mis);
      chk("overrun", ovr, m_ovr);
      if (m_q.size() > 0) begin
        chk("word_out", ifc.word_out, m_q[0].word);
        chk("mask_out", ifc.mask_out, m_q[0].mask);
        chk("addr_out", ifc.addr_out, m_q[0].addr);
      end
    end
  end

  task automatic drive_store(input logic [2:0] f, input logic [1:0] off, input logic [9:0] a,
                             input logic [31:0] v, input bit gaps, input bit rnd_ready, input int inj);
    int n;
    n = (f <= 3'd2) ? (8 << int'(f)) : 8;
    func = f; boff = off; waddr = a;
    start = 1; bit_valid = 1; bit_in = v[0];
    if (rnd_ready) ifc.out_ready = 1'($urandom_range(0, 1));
    step();
    start = 0; bit_valid = 0;
    if (!m_legal(f, off)) return;
    for (int k = 1; k < n; k++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        bit_valid = 0;
        if (rnd_ready) ifc.out_ready = 1'($urandom_range(0, 1));
        step();
      end
      bit_valid = 1; bit_in = v[k];
      if (k == inj) begin start = 1; func = 3'd0; end
      if (rnd_ready) ifc.out_ready = 1'($urandom_range(0, 1));
      step();
      start = 0;
    end
    bit_valid = 0;
  endtask

  task automatic drain();
    int i;
    ifc.out_ready = 1;
    i = 0;
    while ((m_q.size() > 0 || m_hold) && i < 20) begin step(); i++; end
    if (m_q.size() > 0 || m_hold) chk("drain_timeout", 1, 0);
    ifc.out_ready = 0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((m_active || m_hold) && i < 200) begin
      ifc.out_ready = 1'($urandom_range(0, 1));
      step(); i++;
    end
    if (m_active || m_hold) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    int         r;
    rst = 1; start = 0; func = 0; boff = 0; waddr = 0; bit_in = 0; bit_valid = 0;
    ifc.out_ready = 0;
    step();
    chk_en = 1;
    step();
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_word", ifc.word_out, 0);
    chk("rst_mask", ifc.mask_out, 0);
    chk("rst_addr", ifc.addr_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mis", mis, 0);
    chk("rst_ovr", ovr, 0);
    rst = 0;

    // SW offset 0
    drive_store(3'd2, 2'd0, 10'h155, 32'hDEADBEEF, 0, 0, -1);
    chk("sw_valid", ifc.out_valid, 1);
    chk("sw_word", ifc.word_out, 32'hDEADBEEF);
    chk("sw_mask", ifc.mask_out, 4'b1111);
    chk("sw_addr", ifc.addr_out, 10'h155);
    drain();

    // SB offset 2
    drive_store(3'd0, 2'd2, 10'h003, 32'h000000A5, 0, 0, -1);
    chk("sb_word", ifc.word_out, 32'h00A50000);
    chk("sb_mask", ifc.mask_out, 4'b0100);
    drain();

    // Misaligned SH then legal SH
    drive_store(3'd1, 2'd3, 10'h010, 32'h0000FFFF, 0, 0, -1);
    chk("mis_pulse", mis, 1);
    step();
    chk("mis_clear", mis, 0);
    chk("mis_novalid", ifc.out_valid, 0);
    drive_store(3'd1, 2'd2, 10'h011, 32'h00001234, 0, 0, -1);
    chk("sh_word", ifc.word_out, 32'h12340000);
    chk("sh_mask", ifc.mask_out, 4'b1100);
    drain();

    // Start while busy
    drive_store(3'd1, 2'd0, 10'h020, 32'h0000BEEF, 1, 0, 5);
    chk("sb_ovr", ovr, 1);
    chk("sb_busy_word", ifc.word_out, 32'h0000BEEF);
    chk("sb_busy_mask", ifc.mask_out, 4'b0011);
    drain();

    // Backpressure
    rst = 1; step(); rst = 0;
    drive_store(3'd0, 2'd0, 10'h001, 32'h11, 0, 0, -1);
    drive_store(3'd0, 2'd1, 10'h002, 32'h22, 0, 0, -1);
    drive_store(3'd0, 2'd3, 10'h003, 32'h33, 0, 0, -1);
    chk("bp_busy", busy, 1);
    chk("bp_ovr0", ovr, 0);
    bit_valid = 1; bit_in = 1; step(); bit_valid = 0;
    chk("bp_ovr", ovr, 1);
    chk("bp_w0", ifc.word_out, 32'h00000011);
    chk("bp_m0", ifc.mask_out, 4'b0001);
    ifc.out_ready = 1;
    step();
    chk("bp_w1", ifc.word_out, 32'h00002200);
    chk("bp_a1", ifc.addr_out, 10'h002);
    chk("bp_idle", busy, 0);
    step();
    chk("bp_w2", ifc.word_out, 32'h33000000);
    chk("bp_m2", ifc.mask_out, 4'b1000);
    step();
    chk("bp_empty", ifc.out_valid, 0);
    ifc.out_ready = 0;

    // Mid-operation reset
    drive_store(3'd0, 2'd0, 10'h005, 32'h5A, 0, 0, -1);
    func = 3'd2; boff = 0; waddr = 10'h077; start = 1; bit_valid = 1; bit_in = 1;
    step();
    start = 0;
    for (int k = 1; k < 10; k++) begin bit_in = 1'($urandom_range(0, 1)); step(); end
    bit_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("mr_valid", ifc.out_valid, 0);
    chk("mr_word", ifc.word_out, 0);
    chk("mr_mask", ifc.mask_out, 0);
    chk("mr_addr", ifc.addr_out, 0);
    chk("mr_busy", busy, 0);
    chk("mr_mis", mis, 0);
    chk("mr_ovr", ovr, 0);
    drive_store(3'd0, 2'd1, 10'h2AA, 32'h3C, 0, 0, -1);
    chk("mr_sb_word", ifc.word_out, 32'h00003C00);
    chk("mr_sb_mask", ifc.mask_out, 4'b0010);
    chk("mr_sb_addr", ifc.addr_out, 10'h2AA);
    drain();

    // Randomized traffic
    for (int s = 0; s < 200; s++) begin
      wait_idle();
      r = $urandom_range(0, 29);
      if (r == 0) begin rst = 1; step(); rst = 0; end
      else if (r == 1) begin bit_valid = 1; bit_in = 1; step(); bit_valid = 0; end
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(3, 7));
      else f = 3'($urandom_range(0, 2));
      drive_store(f, 2'($urandom_range(0, 3)), 10'($urandom), $urandom, 1, 1,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : -1);
    end
    wait_idle();
    drain();
    step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
